// File: rtl/maxnet_controller.sv
// -----------------------------------------------------------------------------
// maxnet_controller
//   Sequencing FSM for a four-neuron MaxNet datapath. A run loads the initial
//   activations, then alternates CHECK (inspect neuron-activity flags) and
//   UPDATE (commit one inhibition step) until at most one neuron is nonzero
//   or the iteration limit is hit. The outcome is latched, done pulses for
//   one cycle and the FSM returns to IDLE.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request, sampled only in IDLE
//   z1..z4            : datapath flags, zi=1 when neuron i is nonzero
//   ld_init           : one-cycle load of external inputs into neuron regs
//   ld_update         : one-cycle commit of an inhibition step
//   busy              : high in every state except IDLE
//   done              : one-cycle completion pulse
//   found, timeout    : latched outcome of the last run
//   winner            : latched index of the surviving neuron (z1->0 .. z4->3)
//   iter_count        : update steps performed in the current or last run
// -----------------------------------------------------------------------------
module maxnet_controller #(
  parameter int unsigned MAX_ITER  = 63,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 z1,
  input  logic                 z2,
  input  logic                 z3,
  input  logic                 z4,
  output logic                 ld_init,
  output logic                 ld_update,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 timeout,
  output logic [1:0]           winner,
  output logic [CNT_WIDTH-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    UPDATE,
    FINISH
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_ITER);

  state_e                 state_q, state_d;
  logic                   found_q, found_d;
  logic                   timeout_q, timeout_d;
  logic [1:0]             winner_q, winner_d;
  logic [CNT_WIDTH-1:0]   iter_q, iter_d;

  logic [2:0]             n_active;
  logic                   at_most_one;

  // Number of neurons still active; only consulted in CHECK.
  always_comb begin
    n_active    = {2'b00, z1} + {2'b00, z2} + {2'b00, z3} + {2'b00, z4};
    at_most_one = (n_active <= 3'd1);
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      winner_q  <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
      winner_q  <= winner_d;
      iter_q    <= iter_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d   = state_q;
    found_d   = found_q;
    timeout_d = timeout_q;
    winner_d  = winner_q;
    iter_d    = iter_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        found_d   = 1'b0;
        timeout_d = 1'b0;
        winner_d  = '0;
        iter_d    = '0;
        state_d   = CHECK;
      end
      CHECK: begin
        if (at_most_one) begin
          state_d   = FINISH;
          found_d   = (n_active == 3'd1);
          timeout_d = 1'b0;
          // One-hot to index; yields 0 when no neuron is active.
          winner_d  = {z3 | z4, z2 | z4};
        end else if (iter_q == MAX_CNT) begin
          state_d   = FINISH;
          found_d   = 1'b0;
          timeout_d = 1'b1;
          winner_d  = '0;
        end else begin
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        if (iter_q != '1) iter_d = iter_q + 1'b1;
        state_d = CHECK;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    ld_init   = 1'b0;
    ld_update = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE:    busy      = 1'b0;
      LOAD:    ld_init   = 1'b1;
      CHECK:   ;
      UPDATE:  ld_update = 1'b1;
      FINISH:  done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign found      = found_q;
  assign timeout    = timeout_q;
  assign winner     = winner_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
module tb_maxnet_controller;

  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    zv = 4'b0000;   // zv[3]=z1 .. zv[0]=z4, literals read z1z2z3z4
  logic          ld_init, ld_update, busy, done, found, timeout;
  logic [1:0]    winner;
  logic [CW-1:0] iter_count;

  maxnet_controller #(.MAX_ITER(4), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .z1         (zv[3]),
    .z2         (zv[2]),
    .z3         (zv[1]),
    .z4         (zv[0]),
    .ld_init    (ld_init),
    .ld_update  (ld_update),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .timeout    (timeout),
    .winner     (winner),
    .iter_count (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        found;
    logic        timeout;
    logic [1:0]  winner;
    int unsigned k;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  zseq[4];
  int unsigned zlen = 1;

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge, pops expectations on done,
  // and plays back the flag sequence for the run in flight.
  int unsigned cyc = 0, load_cyc = 0, upd_seen = 0, idx;
  logic        h_found = 1'b0, h_timeout = 1'b0;
  logic [1:0]  h_winner = '0;
  int unsigned h_iter = 0;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb_q.delete();
      h_found = 1'b0; h_timeout = 1'b0; h_winner = '0; h_iter = 0;
      upd_seen = 0;
    end else begin
      if (ld_init) begin
        load_cyc = cyc;
        upd_seen = 0;
      end
      if (ld_update) upd_seen++;
      if (!busy)
        chk("idle_hold", {ld_init, ld_update, done, found, timeout, winner, 32'(iter_count)},
                         {1'b0, 1'b0, 1'b0, h_found, h_timeout, h_winner, 32'(h_iter)});
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("found",      found, e.found);
          chk("timeout",    timeout, e.timeout);
          chk("winner",     winner, e.winner);
          chk("iter_count", iter_count, e.k);
          chk("n_updates",  upd_seen, e.k);
          chk("latency",    cyc - load_cyc, 2 + 2 * e.k);
          h_found = e.found; h_timeout = e.timeout; h_winner = e.winner; h_iter = e.k;
        end
      end
    end
    // Flags only matter in CHECK; outside a run they are scrambled.
    if (!busy || done) zv = 4'($urandom);
    else begin
      idx = (upd_seen < zlen) ? upd_seen : zlen - 1;
      zv = zseq[idx];
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_run(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] s3, input int unsigned len, input logic f,
                        input logic t, input logic [1:0] w, input int unsigned k);
    exp_t x;
    zseq[0] = s0; zseq[1] = s1; zseq[2] = s2; zseq[3] = s3; zlen = len;
    x.found = f; x.timeout = t; x.winner = w; x.k = k;
    sb_q.push_back(x);
    pulse_start();
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_wait_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Immediate winner: only z3
    do_run(4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 1'b1, 1'b0, 2'd2, 0);
    wait_done(); repeat (2) @(posedge clk);

    // Convergence after three updates to z1
    do_run(4'b1111, 4'b1111, 4'b1111, 4'b1000, 4, 1'b1, 1'b0, 2'd0, 3);
    wait_done(); repeat (2) @(posedge clk);

    // All neurons die after one update
    do_run(4'b1100, 4'b0000, 4'b0000, 4'b0000, 2, 1'b0, 1'b0, 2'd0, 1);
    wait_done(); repeat (2) @(posedge clk);

    // Iteration limit (MAX_ITER=4)
    do_run(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1, 1'b0, 1'b1, 2'd0, 4);
    wait_done(); repeat (2) @(posedge clk);

    // Reset during the second UPDATE: no expectation queued, no done allowed
    zseq[0] = 4'b1111; zlen = 1;
    pulse_start();                       // now in LOAD
    repeat (4) @(posedge clk);           // CHECK, UPDATE, CHECK, UPDATE
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    do_run(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 1'b1, 1'b0, 2'd3, 0);
    wait_done(); repeat (2) @(posedge clk);

    // Start while busy is ignored; then back-to-back run right after done
    do_run(4'b1111, 4'b0100, 4'b0100, 4'b0100, 2, 1'b1, 1'b0, 2'd1, 1);
    @(posedge clk); #1 start = 1'b1;     // during CHECK
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    do_run(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1'b0, 1'b0, 2'd0, 0);
    wait_done(); repeat (4) @(posedge clk);

    chk("queue_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
